// File: rtl/photo_shutter_seq.sv
// Photoshutter sequencer: pulses NCHAN shutter outputs in mask order with
// programmable width, gap and repeat count, controlled over the local register bus.
module photo_shutter_seq #(
  parameter int NCHAN     = 3,
  parameter int CNT_WIDTH = 16,
  parameter int PRESCALE  = 100
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [1:0]       adr_i,
  input  logic [31:0]      dat_i,
  output logic [31:0]      dat_o,
  input  logic             trig_i,
  output logic [NCHAN-1:0] shutter_o,
  output logic             trig_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  state_t                 state_q, state_d;
  logic                   arm_q, arm_d;
  logic                   exten_q, exten_d;
  logic [7:0]             mask_q, mask_d;
  logic [15:0]            shots_q, shots_d;
  logic [CNT_WIDTH-1:0]   width_q, width_d;
  logic [CNT_WIDTH-1:0]   gap_q, gap_d;
  logic [CNT_WIDTH-1:0]   lat_width_q, lat_width_d;
  logic [CNT_WIDTH-1:0]   lat_gap_q, lat_gap_d;
  logic [NCHAN-1:0]       lat_mask_q, lat_mask_d;
  logic [15:0]            lat_shots_q, lat_shots_d;
  logic [2:0]             ch_q, ch_d;
  logic [PW-1:0]          pre_q, pre_d;
  logic [CNT_WIDTH-1:0]   tick_cnt_q, tick_cnt_d;
  logic [15:0]            done_q, done_d;
  logic [7:0]             missed_q, missed_d;
  logic                   trig_prev_q, trig_prev_d;
  logic                   trig_pend_q, trig_pend_d;
  logic [NCHAN-1:0]       shutter_q, shutter_d;
  logic                   trig_o_q, trig_o_d;
  logic                   busy_q, busy_d;
  logic [31:0]            dat_q, dat_d;

  logic                   ctrl_wr, width_wr, gap_wr;
  logic                   arm_e, exten_e, trig_ev, tick, do_next, abort;
  logic [NCHAN-1:0]       mask_e;
  logic [15:0]            shots_e, shots_eff;
  logic [CNT_WIDTH-1:0]   width_e, gap_e, wlast;
  logic [3:0]             nxt;
  logic                   unused_bits;

  function automatic logic [2:0] lowest_set(input logic [NCHAN-1:0] m);
    lowest_set = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = 3'(i);
    end
  endfunction

  // Bit 3 flags that a set mask bit above channel c exists; bits 2:0 give it.
  function automatic logic [3:0] next_set(input logic [NCHAN-1:0] m, input logic [2:0] c);
    next_set = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (m[i] && (i > int'(c))) next_set = {1'b1, 3'(i)};
    end
  endfunction

  assign ctrl_wr  = wr_i && (adr_i == 2'd0);
  assign width_wr = wr_i && (adr_i == 2'd1);
  assign gap_wr   = wr_i && (adr_i == 2'd2);

  // Same-cycle writes are visible to trigger acceptance and latching.
  assign arm_e   = ctrl_wr  ? dat_i[0] : arm_q;
  assign exten_e = ctrl_wr  ? dat_i[2] : exten_q;
  assign mask_e  = ctrl_wr  ? dat_i[8 +: NCHAN] : mask_q[NCHAN-1:0];
  assign shots_e = ctrl_wr  ? dat_i[31:16] : shots_q;
  assign width_e = width_wr ? dat_i[CNT_WIDTH-1:0] : width_q;
  assign gap_e   = gap_wr   ? dat_i[CNT_WIDTH-1:0] : gap_q;
  assign trig_ev = (ctrl_wr && dat_i[1]) || (trig_i && !trig_prev_q && exten_e);

  assign tick      = (pre_q == PRE_LAST);
  assign shots_eff = (lat_shots_q == 16'd0) ? 16'd1 : lat_shots_q;
  assign wlast     = (lat_width_q == '0) ? '0 : lat_width_q - CNT_WIDTH'(1);
  assign abort     = ctrl_wr && !dat_i[0] && (state_q != ST_IDLE);
  assign nxt       = next_set(lat_mask_q, ch_q);

  assign unused_bits = ^dat_i[7:3];

  always_comb begin
    state_d     = state_q;
    arm_d       = arm_q;
    exten_d     = exten_q;
    mask_d      = mask_q;
    shots_d     = shots_q;
    width_d     = width_q;
    gap_d       = gap_q;
    lat_width_d = lat_width_q;
    lat_gap_d   = lat_gap_q;
    lat_mask_d  = lat_mask_q;
    lat_shots_d = lat_shots_q;
    ch_d        = ch_q;
    done_d      = done_q;
    missed_d    = missed_q;
    trig_prev_d = trig_i;
    trig_pend_d = 1'b0;
    do_next     = 1'b0;
    pre_d       = tick ? '0 : pre_q + PW'(1);
    tick_cnt_d  = tick ? tick_cnt_q + CNT_WIDTH'(1) : tick_cnt_q;

    if (ctrl_wr) begin
      arm_d   = dat_i[0];
      exten_d = dat_i[2];
      mask_d  = dat_i[15:8];
      shots_d = dat_i[31:16];
    end
    if (width_wr) width_d = dat_i[CNT_WIDTH-1:0];
    if (gap_wr)   gap_d   = dat_i[CNT_WIDTH-1:0];

    case (state_q)
      ST_IDLE: begin
        if (trig_ev && arm_e && (mask_e != '0)) begin
          state_d     = ST_PULSE;
          ch_d        = lowest_set(mask_e);
          lat_width_d = width_e;
          lat_gap_d   = gap_e;
          lat_mask_d  = mask_e;
          lat_shots_d = shots_e;
          done_d      = '0;
          trig_pend_d = 1'b1;
          pre_d       = '0;
          tick_cnt_d  = '0;
        end
      end
      ST_PULSE: begin
        if (tick && (tick_cnt_q == wlast)) begin
          if (lat_gap_q != '0) begin
            state_d    = ST_GAP;
            pre_d      = '0;
            tick_cnt_d = '0;
          end else begin
            do_next = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (tick && (tick_cnt_q == lat_gap_q - CNT_WIDTH'(1))) do_next = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Advance to the next mask channel, wrapping to a new shot when exhausted.
    if (do_next) begin
      pre_d      = '0;
      tick_cnt_d = '0;
      if (nxt[3]) begin
        state_d = ST_PULSE;
        ch_d    = nxt[2:0];
      end else begin
        done_d = done_q + 16'd1;
        if ((done_q + 16'd1) < shots_eff) begin
          state_d = ST_PULSE;
          ch_d    = lowest_set(lat_mask_q);
        end else begin
          state_d = ST_IDLE;
        end
      end
    end

    if ((state_q != ST_IDLE) && trig_ev && (missed_q != 8'hFF)) missed_d = missed_q + 8'd1;

    if (abort) begin
      state_d    = ST_IDLE;
      pre_d      = '0;
      tick_cnt_d = '0;
    end

    shutter_d = ((state_q == ST_PULSE) && !abort) ? (NCHAN'(1) << ch_q) : '0;
    busy_d    = (state_q != ST_IDLE) && !abort;
    trig_o_d  = trig_pend_q;

    case (adr_i)
      2'd0:    dat_d = {shots_q, mask_q, 5'b0, exten_q, 1'b0, arm_q};
      2'd1:    dat_d = 32'(width_q);
      2'd2:    dat_d = 32'(gap_q);
      default: dat_d = {done_q, missed_q, 1'b0, ch_q, 1'b0, state_q, busy_q};
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      arm_q       <= 1'b0;
      exten_q     <= 1'b0;
      mask_q      <= '0;
      shots_q     <= '0;
      width_q     <= CNT_WIDTH'(1);
      gap_q       <= CNT_WIDTH'(1);
      lat_width_q <= '0;
      lat_gap_q   <= '0;
      lat_mask_q  <= '0;
      lat_shots_q <= '0;
      ch_q        <= '0;
      pre_q       <= '0;
      tick_cnt_q  <= '0;
      done_q      <= '0;
      missed_q    <= '0;
      trig_prev_q <= 1'b0;
      trig_pend_q <= 1'b0;
      shutter_q   <= '0;
      trig_o_q    <= 1'b0;
      busy_q      <= 1'b0;
      dat_q       <= '0;
    end else begin
      state_q     <= state_d;
      arm_q       <= arm_d;
      exten_q     <= exten_d;
      mask_q      <= mask_d;
      shots_q     <= shots_d;
      width_q     <= width_d;
      gap_q       <= gap_d;
      lat_width_q <= lat_width_d;
      lat_gap_q   <= lat_gap_d;
      lat_mask_q  <= lat_mask_d;
      lat_shots_q <= lat_shots_d;
      ch_q        <= ch_d;
      pre_q       <= pre_d;
      tick_cnt_q  <= tick_cnt_d;
      done_q      <= done_d;
      missed_q    <= missed_d;
      trig_prev_q <= trig_prev_d;
      trig_pend_q <= trig_pend_d;
      shutter_q   <= shutter_d;
      trig_o_q    <= trig_o_d;
      busy_q      <= busy_d;
      dat_q       <= dat_d;
    end
  end

  assign shutter_o = shutter_q;
  assign trig_o    = trig_o_q;
  assign busy_o    = busy_q;
  assign dat_o     = dat_q;

endmodule

// File: tb/tb_photo_shutter_seq.sv
// Randomized bench for photo_shutter_seq: expected shutter waveforms are built
// from the mask/width/gap/shots rules as flat per-clock lists.
module tb_photo_shutter_seq;
  localparam int NCHAN = 3;
  localparam int PRESC = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr;
  logic [1:0]       adr;
  logic [31:0]      wdat;
  logic [31:0]      rdat;
  logic             trig_in;
  logic [NCHAN-1:0] shutter;
  logic             trig_out;
  logic             busy;

  int vectors      = 0;
  int miscompares  = 0;
  int sh_width     = 1;
  int sh_gap       = 1;
  int missed_model = 0;

  photo_shutter_seq #(.NCHAN(NCHAN), .CNT_WIDTH(16), .PRESCALE(PRESC)) dut (
    .clk_i(clk), .rst_i(rst), .wr_i(wr), .adr_i(adr), .dat_i(wdat), .dat_o(rdat),
    .trig_i(trig_in), .shutter_o(shutter), .trig_o(trig_out), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
    wr = 1'b1; adr = a; wdat = d;
    step();
    wr = 1'b0;
  endtask

  task automatic readReg(input logic [1:0] a, output logic [31:0] d);
    adr = a;
    step();
    d = rdat;
  endtask

  // Runs one triggered sequence and compares {trig_o, busy_o, shutter_o} every clock.
  task automatic applyStimulus(input int mask, input int shots, input bit use_ext,
                               input bit exten, input int noise, input int mid_width);
    logic [NCHAN-1:0] expq[$];
    logic [NCHAN-1:0] ev;
    logic [31:0]      ctrl;
    logic [31:0]      st;
    int wv, gv, sv, len, edges, mid;
    wv = (sh_width == 0) ? 1 : sh_width;
    gv = sh_gap;
    sv = (shots == 0) ? 1 : shots;
    for (int s = 0; s < sv; s++)
      for (int c = 0; c < NCHAN; c++)
        if (mask[c]) begin
          repeat (wv * PRESC) expq.push_back(NCHAN'(1 << c));
          repeat (gv * PRESC) expq.push_back('0);
        end
    ctrl = {16'(shots), 8'(mask), 5'b0, exten, 1'b0, 1'b1};
    if (use_ext) begin
      writeReg(2'd0, ctrl);
      trig_in = 1'b1;
      step();
      trig_in = 1'b0;
    end else begin
      writeReg(2'd0, ctrl | 32'h2);
    end
    len = expq.size();
    edges = 0;
    mid = len / 2;
    for (int i = 0; i < len + 2; i++) begin
      step();
      wr = 1'b0;
      ev = (i < len) ? expq[i] : '0;
      checkOutput("seq.outputs", 32'({trig_out, busy, shutter}), 32'({(i == 0), (i < len), ev}));
      if (noise != 0 && trig_in == 1'b0 && i >= 1 && i <= len - 3 &&
          (noise == 2 || $urandom_range(0, 2) == 0)) begin
        trig_in = 1'b1;
        if (exten) edges++;
      end else begin
        trig_in = 1'b0;
      end
      if (mid_width >= 0 && i == mid) begin
        wr = 1'b1; adr = 2'd1; wdat = 32'(mid_width);
        sh_width = mid_width;
      end
    end
    trig_in = 1'b0;
    missed_model = (missed_model + edges > 255) ? 255 : missed_model + edges;
    readReg(2'd3, st);
    checkOutput("status.shots", 32'(st[31:16]), 32'(sv));
    checkOutput("status.missed", 32'(st[15:8]), 32'(missed_model));
    checkOutput("status.idle", 32'(st[2:0]), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int m, w, g, s, ue, ex, mw;
    rst = 1'b1; wr = 1'b0; adr = 2'd0; wdat = '0; trig_in = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    checkOutput("reset.outputs", 32'({trig_out, busy, shutter}), 32'd0);
    checkOutput("reset.dat_o", rdat, 32'd0);
    readReg(2'd0, rd); checkOutput("reset.ctrl", rd, 32'h0);
    readReg(2'd1, rd); checkOutput("reset.width", rd, 32'h1);
    readReg(2'd2, rd); checkOutput("reset.gap", rd, 32'h1);
    readReg(2'd3, rd); checkOutput("reset.status", rd, 32'h0);

    // Three channels, width 2, gap 1, software trigger.
    writeReg(2'd1, 32'd2); sh_width = 2;
    writeReg(2'd2, 32'd1); sh_gap = 1;
    applyStimulus(7, 0, 1'b0, 1'b0, 0, -1);

    // Mask 0x5, two shots, no gap, external edge with missed triggers.
    writeReg(2'd2, 32'd0); sh_gap = 0;
    applyStimulus(5, 2, 1'b1, 1'b1, 1, -1);

    // A width write mid-sequence only affects the following sequence.
    writeReg(2'd2, 32'd1); sh_gap = 1;
    applyStimulus(7, 1, 1'b0, 1'b0, 0, 5);
    applyStimulus(1, 1, 1'b0, 1'b0, 0, -1);

    // Disarmed or empty-mask triggers are dropped silently.
    writeReg(2'd0, 32'h0000_0702);
    repeat (3) begin
      step();
      checkOutput("drop.disarmed", 32'({trig_out, busy, shutter}), 32'd0);
    end
    writeReg(2'd0, 32'h0000_0003);
    repeat (3) begin
      step();
      checkOutput("drop.nomask", 32'({trig_out, busy, shutter}), 32'd0);
    end
    readReg(2'd3, rd);
    checkOutput("drop.missed", 32'(rd[15:8]), 32'(missed_model));

    // Abort while channel 1 is pulsing.
    writeReg(2'd1, 32'd2); sh_width = 2;
    writeReg(2'd2, 32'd1); sh_gap = 1;
    writeReg(2'd0, 32'h0000_0703);
    for (int i = 0; i < 14; i++) step();
    checkOutput("abort.pre", 32'(shutter), 32'h2);
    writeReg(2'd0, 32'h0000_0700);
    checkOutput("abort.outputs", 32'({trig_out, busy, shutter}), 32'd0);
    readReg(2'd3, rd);
    checkOutput("abort.state", 32'(rd[2:0]), 32'd0);
    checkOutput("abort.shots", 32'(rd[31:16]), 32'd0);
    repeat (4) step();
    checkOutput("abort.stays", 32'({trig_out, busy, shutter}), 32'd0);

    // Random configurations.
    repeat (16) begin
      m  = int'($urandom_range(1, 7));
      w  = int'($urandom_range(0, 3));
      g  = int'($urandom_range(0, 2));
      s  = int'($urandom_range(0, 2));
      ue = int'($urandom_range(0, 1));
      ex = (ue == 1) ? 1 : int'($urandom_range(0, 1));
      mw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      writeReg(2'd1, 32'(w)); sh_width = w;
      writeReg(2'd2, 32'(g)); sh_gap = g;
      applyStimulus(m, s, ue[0], ex[0], 1, mw);
    end

    // Long pulse with an edge every other clock drives the missed count to saturation.
    writeReg(2'd1, 32'd255); sh_width = 255;
    writeReg(2'd2, 32'd0); sh_gap = 0;
    applyStimulus(1, 1, 1'b1, 1'b1, 2, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
